// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 16-bit binary to 4-digit packed BCD using iterative double-dabble.
// It performs one shift-add-3 step per clock, so a conversion takes 16 clocks.
// The start/busy/done handshake brackets each conversion.
// bcd_out and ovf change only when a conversion completes or on reset.
// Optional macro BIN2BCD_SATURATE_EN: when defined, a result above 9999 clamps bcd_out to 16'h9999.
module bin2bcd_seq #(
   parameter int unsigned NBITS    = 16,
   parameter int unsigned NDIG_OUT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NBITS-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*NDIG_OUT-1:0] bcd_out,
   output logic                  ovf
);

   localparam int unsigned NDIG_INT = 5;
   localparam int unsigned BCD_W    = 4 * NDIG_INT;
   localparam int unsigned SR_W     = BCD_W + NBITS;
   localparam int unsigned OUT_W    = 4 * NDIG_OUT;
   localparam int unsigned CNT_W    = 4;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);
   localparam logic [OUT_W-1:0] SAT_VAL  = OUT_W'(16'h9999);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [OUT_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic [SR_W-1:0]    sr_adj;
   logic [SR_W-1:0]    sr_shift;
   logic               last_step;

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_q;
   assign ovf     = ovf_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         bcd_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         bcd_q  <= bcd_d;
         ovf_q  <= ovf_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == LAST_CNT) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Add-3 correction per BCD nibble (4-bit, no inter-nibble carry), then shift
   always_comb begin
      sr_adj = sr_q;
      for (int d = 0; d < int'(NDIG_INT); d++) begin
         if (sr_q[NBITS + 4*d +: 4] >= 4'd5)
            sr_adj[NBITS + 4*d +: 4] = sr_q[NBITS + 4*d +: 4] + 4'd3;
      end
      sr_shift  = {sr_adj[SR_W-2:0], 1'b0};
      last_step = (cnt_q == LAST_CNT);
   end

   // Datapath and output next values
   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      bcd_d  = bcd_q;
      ovf_d  = ovf_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               sr_d   = {BCD_W'(0), bin_in};
               cnt_d  = '0;
               busy_d = 1'b1;
            end
         end
         S_SHIFT: begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               ovf_d  = (sr_shift[SR_W-1 -: 4] != 4'd0);
`ifdef BIN2BCD_SATURATE_EN
               bcd_d  = (sr_shift[SR_W-1 -: 4] != 4'd0) ? SAT_VAL : sr_shift[NBITS +: OUT_W];
`else
               bcd_d  = sr_shift[NBITS +: OUT_W];
`endif
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

`ifndef BIN2BCD_SATURATE_EN
   // Saturation constant is only referenced in the clamping build
   logic unused_sat;
   assign unused_sat = ^SAT_VAL;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq.
// Honours BIN2BCD_SATURATE_EN for the expected overflow results.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] bin_in;
   logic        busy;
   logic        done;
   logic [15:0] bcd_out;
   logic        ovf;

   int n_cmp = 0;
   int n_err = 0;

`ifdef BIN2BCD_SATURATE_EN
   localparam logic [15:0] EXP_10000 = 16'h9999;
   localparam logic [15:0] EXP_65535 = 16'h9999;
`else
   localparam logic [15:0] EXP_10000 = 16'h0000;
   localparam logic [15:0] EXP_65535 = 16'h5535;
`endif

   bin2bcd_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full conversion: accept, 15 busy cycles, done on the 16th edge, then done drops
   task automatic convert(input logic [15:0] val, input logic [15:0] exp_bcd, input logic exp_ovf);
      logic early_done;
      logic busy_drop;
      early_done = 1'b0;
      busy_drop  = 1'b0;
      @(negedge clk);
      bin_in = val;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      bin_in = 16'hDEAD;
      chk("busy_after_start", 32'(busy), 32'd1);
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         if (done)  early_done = 1'b1;
         if (!busy) busy_drop  = 1'b1;
      end
      chk("done_early", 32'(early_done), 32'd0);
      chk("busy_held", 32'(busy_drop), 32'd0);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("bcd_hold", 32'(bcd_out), 32'(exp_bcd));
   endtask

   initial begin
      logic seen;
      rst    = 1'b1;
      start  = 1'b0;
      bin_in = 16'h0000;
      #22;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd_out), 32'h0000);
      chk("rst_ovf", 32'(ovf), 32'd0);

      convert(16'h04D2, 16'h1234, 1'b0);
      convert(16'h270F, 16'h9999, 1'b0);
      convert(16'h2710, EXP_10000, 1'b1);
      convert(16'hFFFF, EXP_65535, 1'b1);
      convert(16'h0000, 16'h0000, 1'b0);

      // Start while busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      bin_in = 16'h04D2;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (i == 15) begin
            chk("ign_busy", 32'(busy), 32'd1);
            chk("ign_done", 32'(done), 32'd0);
         end
         if (i == 4) begin
            start  = 1'b1;
            bin_in = 16'h0000;
         end
      end
      @(posedge clk); #1;
      chk("ign_done_pulse", 32'(done), 32'd1);
      chk("ign_bcd", 32'(bcd_out), 32'h1234);
      start  = 1'b1;
      bin_in = 16'h0007;
      @(posedge clk); #1;
      start  = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done_low", 32'(done), 32'd0);
      seen = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("b2b_no_early", 32'(seen), 32'd0);
      @(posedge clk); #1;
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_bcd", 32'(bcd_out), 32'h0007);

      // Reset in mid-conversion aborts at once
      convert(16'h04D2, 16'h1234, 1'b0);
      @(negedge clk);
      bin_in = 16'h0063;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_bcd", 32'(bcd_out), 32'h0000);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      chk("abort_quiet", 32'(seen), 32'd0);
      convert(16'h0000, 16'h0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
